// File: rtl/shift_out_595_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shift_out_595_ctrl
// Purpose  : Word-to-serial controller for a 74HC595-style SIPO chain with a
//            divided shift clock and a storage latch pulse.
// Option   : SHIFT_LSB_FIRST_EN - when defined, data[0] is shifted out first.
// Revision : 1.0 - initial release
// ============================================================================
module shift_out_595_ctrl #(
    parameter int N       = 8,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] data,
    input  logic         valid,
    output logic         ready,
    output logic         sdata,
    output logic         sclk,
    output logic         latch,
    output logic         busy,
    output logic         done
);

    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_BIT_W = $clog2(N);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT_LO = 2'd1,
        S_SHIFT_HI = 2'd2,
        S_LATCH    = 2'd3
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [N-1:0]         r_shreg_q, w_shreg_d;
    logic [C_DIV_W-1:0]   r_div_q,   w_div_d;
    logic [C_BIT_W-1:0]   r_bit_q,   w_bit_d;
    logic                 r_ready_q, w_ready_d;
    logic                 r_sdata_q, w_sdata_d;
    logic                 r_sclk_q,  w_sclk_d;
    logic                 r_latch_q, w_latch_d;
    logic                 r_busy_q,  w_busy_d;
    logic                 r_done_q,  w_done_d;

    logic                 w_div_end;
    logic                 w_data_head;
    logic [N-1:0]         w_data_rest;
    logic                 w_sh_head;
    logic [N-1:0]         w_sh_rest;

    // The shift register holds the bits still to be sent after the one on sdata.
`ifdef SHIFT_LSB_FIRST_EN
    assign w_data_head = data[0];
    assign w_data_rest = {1'b0, data[N-1:1]};
    assign w_sh_head   = r_shreg_q[0];
    assign w_sh_rest   = {1'b0, r_shreg_q[N-1:1]};
`else
    assign w_data_head = data[N-1];
    assign w_data_rest = {data[N-2:0], 1'b0};
    assign w_sh_head   = r_shreg_q[N-1];
    assign w_sh_rest   = {r_shreg_q[N-2:0], 1'b0};
`endif

    assign w_div_end = (r_div_q == C_DIV_LAST);

    always_comb begin
        w_state_d = r_state_q;
        w_shreg_d = r_shreg_q;
        w_div_d   = r_div_q;
        w_bit_d   = r_bit_q;
        w_ready_d = r_ready_q;
        w_sdata_d = r_sdata_q;
        w_sclk_d  = r_sclk_q;
        w_latch_d = r_latch_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_ready_d = 1'b1;
                w_busy_d  = 1'b0;
                if (valid && r_ready_q) begin
                    w_shreg_d = w_data_rest;
                    w_sdata_d = w_data_head;
                    w_sclk_d  = 1'b0;
                    w_div_d   = '0;
                    w_bit_d   = '0;
                    w_ready_d = 1'b0;
                    w_busy_d  = 1'b1;
                    w_state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (w_div_end) begin
                    w_div_d   = '0;
                    w_sclk_d  = 1'b1;
                    w_state_d = S_SHIFT_HI;
                end else begin
                    w_div_d = r_div_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (w_div_end) begin
                    w_div_d  = '0;
                    w_sclk_d = 1'b0;
                    if (r_bit_q == C_BIT_LAST) begin
                        w_bit_d   = '0;
                        w_latch_d = 1'b1;
                        w_state_d = S_LATCH;
                    end else begin
                        w_shreg_d = w_sh_rest;
                        w_sdata_d = w_sh_head;
                        w_bit_d   = r_bit_q + 1'b1;
                        w_state_d = S_SHIFT_LO;
                    end
                end else begin
                    w_div_d = r_div_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (w_div_end) begin
                    w_div_d   = '0;
                    w_latch_d = 1'b0;
                    w_busy_d  = 1'b0;
                    w_ready_d = 1'b1;
                    w_done_d  = 1'b1;
                    w_state_d = S_IDLE;
                end else begin
                    w_div_d = r_div_q + 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q <= S_IDLE;
            r_shreg_q <= '0;
            r_div_q   <= '0;
            r_bit_q   <= '0;
            r_ready_q <= 1'b0;
            r_sdata_q <= 1'b0;
            r_sclk_q  <= 1'b0;
            r_latch_q <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_shreg_q <= w_shreg_d;
            r_div_q   <= w_div_d;
            r_bit_q   <= w_bit_d;
            r_ready_q <= w_ready_d;
            r_sdata_q <= w_sdata_d;
            r_sclk_q  <= w_sclk_d;
            r_latch_q <= w_latch_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign ready = r_ready_q;
    assign sdata = r_sdata_q;
    assign sclk  = r_sclk_q;
    assign latch = r_latch_q;
    assign busy  = r_busy_q;
    assign done  = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_out_595_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shift_out_595_ctrl
// Purpose  : Directed and randomized checks of shift_out_595_ctrl at
//            CLK_DIV=4 and CLK_DIV=1 against a word-level serial model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_out_595_ctrl;

    localparam int N  = 8;
    localparam int D0 = 4;
    localparam int D1 = 1;
`ifdef SHIFT_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] data0, data1;
    logic         valid0, valid1;
    logic         ready0, sdata0, sclk0, latch0, busy0, done0;
    logic         ready1, sdata1, sclk1, latch1, busy1, done1;

    int   sel;
    int   checks = 0;
    int   passes = 0;
    logic m_ready, m_sdata, m_sclk, m_latch, m_busy, m_done;

    always #5 clk = ~clk;

    shift_out_595_ctrl #(.N(N), .CLK_DIV(D0)) dut0 (
        .clk(clk), .reset_n(reset_n), .data(data0), .valid(valid0),
        .ready(ready0), .sdata(sdata0), .sclk(sclk0), .latch(latch0),
        .busy(busy0), .done(done0)
    );

    shift_out_595_ctrl #(.N(N), .CLK_DIV(D1)) dut1 (
        .clk(clk), .reset_n(reset_n), .data(data1), .valid(valid1),
        .ready(ready1), .sdata(sdata1), .sclk(sclk1), .latch(latch1),
        .busy(busy1), .done(done1)
    );

    assign m_ready = (sel == 1) ? ready1 : ready0;
    assign m_sdata = (sel == 1) ? sdata1 : sdata0;
    assign m_sclk  = (sel == 1) ? sclk1  : sclk0;
    assign m_latch = (sel == 1) ? latch1 : latch0;
    assign m_busy  = (sel == 1) ? busy1  : busy0;
    assign m_done  = (sel == 1) ? done1  : done0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Element i is the i-th bit expected on the wire.
    function automatic logic [N-1:0] wire_order(input logic [N-1:0] w);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = LSB_FIRST ? w[i] : w[N-1-i];
        return r;
    endfunction

    task automatic drive(input int s, input logic v, input logic [N-1:0] d);
        if (s == 1) begin
            valid1 = v;
            data1  = d;
        end else begin
            valid0 = v;
            data0  = d;
        end
    endtask

    task automatic xfer(input int s, input logic [N-1:0] w, input bit noise,
                        input bit chain_next, input logic [N-1:0] nw, input bit expect_now);
        int div, waitc, low, rises, lat, viol, dones;
        logic [N-1:0] got;
        logic prev_sclk, prev_sdata;
        div   = (s == 1) ? D1 : D0;
        sel   = s;
        waitc = 0;
        while (!m_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_before_send", 32'(m_ready), 1);
        if (expect_now) chk("b2b_accept_in_done_cycle", waitc, 0);
        drive(s, 1'b1, w);
        @(negedge clk);
        chk("accept_ready_low", 32'(m_ready), 0);
        chk("accept_busy_high", 32'(m_busy), 1);
        chk("accept_done_low", 32'(m_done), 0);
        low = 1; rises = 0; lat = 0; viol = 0; dones = 0; got = '0;
        prev_sclk  = m_sclk;
        prev_sdata = m_sdata;
        while (low < 1000) begin
            if (noise) drive(s, 1'($urandom % 2), N'($urandom));
            else       drive(s, 1'b0, N'($urandom));
            @(negedge clk);
            if (m_ready) break;
            low++;
            if (!prev_sclk && m_sclk) begin
                if (rises < N) got[rises] = m_sdata;
                rises++;
            end
            if (prev_sclk && m_sclk && m_sdata !== prev_sdata) viol++;
            if (m_latch) lat++;
            if (m_done) dones++;
            prev_sclk  = m_sclk;
            prev_sdata = m_sdata;
        end
        chk("done_pulse", 32'(m_done), 1);
        chk("done_busy_low", 32'(m_busy), 0);
        chk("done_latch_low", 32'(m_latch), 0);
        chk("ready_low_cycles", low, 2 * N * div + div);
        chk("serial_bits", 32'(got), 32'(wire_order(w)));
        chk("sclk_rises", rises, N);
        chk("latch_cycles", lat, div);
        chk("sdata_stable_while_sclk_high", viol, 0);
        chk("no_early_done", dones, 0);
        drive(s, chain_next, nw);
    endtask

    initial begin
        int dones;
        logic [N-1:0] rw;
        sel     = 0;
        reset_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready0), 0);
        chk("rst_sclk", 32'(sclk0), 0);
        chk("rst_latch", 32'(latch0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_sdata", 32'(sdata0), 0);
        chk("rst_ready_dut1", 32'(ready1), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(ready0), 1);
        chk("ready_after_release_dut1", 32'(ready1), 1);

        // Single word and back-to-back pair
        xfer(0, 8'hA5, 1'b0, 1'b0, '0, 1'b0);
        xfer(0, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0);
        xfer(0, 8'h00, 1'b0, 1'b0, '0, 1'b1);

        // Upstream keeps toggling valid/data while busy
        xfer(0, N'($urandom), 1'b1, 1'b0, '0, 1'b0);
        xfer(0, 8'h5A, 1'b1, 1'b0, '0, 1'b0);

        // Reset in the high phase of the 4th bit
        sel = 0;
        drive(0, 1'b1, 8'hC3);
        @(negedge clk);
        drive(0, 1'b0, 8'hC3);
        repeat (29) @(negedge clk);
        chk("pre_reset_sclk_high", 32'(sclk0), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_sclk", 32'(sclk0), 0);
        chk("midrst_latch", 32'(latch0), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_done", 32'(done0), 0);
        chk("midrst_ready", 32'(ready0), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 || latch0 || sclk0) dones++;
        end
        chk("no_activity_after_midrst", dones, 0);
        xfer(0, 8'h3C, 1'b0, 1'b0, '0, 1'b0);

        // Fastest divider
        xfer(1, 8'h01, 1'b0, 1'b0, '0, 1'b0);
        xfer(1, 8'h80, 1'b0, 1'b1, 8'h96, 1'b0);
        xfer(1, 8'h96, 1'b1, 1'b0, '0, 1'b1);

        // Randomized words on both dividers
        for (int i = 0; i < 6; i++) begin
            rw = N'($urandom);
            xfer(i % 2, rw, 1'($urandom % 2), 1'b0, '0, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
